// File: rtl/gates_pkg.sv
// Shared definitions for the two-input gate unit and the logic that self-tests it.
package gates_pkg;

  localparam int GATE_W   = 7;
  localparam int IDX_AND  = 0;
  localparam int IDX_OR   = 1;
  localparam int IDX_NOT  = 2;
  localparam int IDX_NAND = 3;
  localparam int IDX_NOR  = 4;
  localparam int IDX_XOR  = 5;
  localparam int IDX_XNOR = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // A vector check fails once, however many output bits disagree.
  function automatic logic any_mismatch(input logic [GATE_W-1:0] mism);
    return |mism;
  endfunction

endpackage

// File: rtl/gates_ref_model.sv
// Combinational golden model of the gate unit: (a, b) -> expected 7-bit output vector.
module gates_ref_model
  import gates_pkg::*;
(
  input  logic              a_i,
  input  logic              b_i,
  output logic [GATE_W-1:0] y_o
);

  // Truth table for every gate output, indexed by the shared bit positions.
  always_comb begin
    y_o           = {GATE_W{1'b0}};
    y_o[IDX_AND]  = a_i & b_i;
    y_o[IDX_OR]   = a_i | b_i;
    y_o[IDX_NOT]  = ~a_i;
    y_o[IDX_NAND] = ~(a_i & b_i);
    y_o[IDX_NOR]  = ~(a_i | b_i);
    y_o[IDX_XOR]  = a_i ^ b_i;
    y_o[IDX_XNOR] = ~(a_i ^ b_i);
  end

endmodule

// File: rtl/gates_bist_checker.sv
// Built-in self-test for the gate unit: walks the 4-entry truth table LOOPS times,
// samples y_in after a settle delay and accumulates a saturating error count and fail mask.
module gates_bist_checker
  import gates_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              a,
  output logic              b,
  input  logic [GATE_W-1:0] y_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [GATE_W-1:0] fail_mask
);

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       LOOP_LAST   = 4'(LOOPS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO    = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1'b1);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        loop_q, loop_d;
  logic [7:0]        settle_q, settle_d;
  logic              a_q, a_d;
  logic              b_q, b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [GATE_W-1:0] mask_q, mask_d;
  logic [GATE_W-1:0] exp_s;
  logic [GATE_W-1:0] mism_s;

  // Reference is fed from the registered stimulus, so it matches what the gate unit sees.
  gates_ref_model u_ref (
    .a_i (a_q),
    .b_i (b_q),
    .y_o (exp_s)
  );

  assign mism_s = y_in ^ exp_s;

  // State and result registers; reset also aborts any run in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      loop_q   <= 4'd0;
      settle_q <= 8'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= ERR_ZERO;
      mask_q   <= {GATE_W{1'b0}};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      loop_q   <= loop_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
    end
  end

  // Next-state, counters and accumulators; status outputs are derived from the next state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    loop_d   = loop_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    pass_d   = pass_q;
    err_d    = err_q;
    mask_d   = mask_q;

    case (state_q)
      IDLE: begin
        a_d = 1'b0;
        b_d = 1'b0;
        if (start) begin
          err_d    = ERR_ZERO;
          mask_d   = {GATE_W{1'b0}};
          pass_d   = 1'b0;
          idx_d    = 2'd0;
          loop_d   = 4'd0;
          settle_d = 8'd0;
          state_d  = SETTLE;
        end else begin
          state_d  = IDLE;
        end
      end

      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = 8'd0;
          state_d  = CHECK;
        end else begin
          settle_d = settle_q + 8'd1;
          state_d  = SETTLE;
        end
      end

      CHECK: begin
        mask_d = mask_q | mism_s;
        if (any_mismatch(mism_s) && (err_q != ERR_MAX)) begin
          err_d = err_q + ERR_ONE;
        end else begin
          err_d = err_q;
        end

        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          a_d     = idx_d[1];
          b_d     = idx_d[0];
          state_d = SETTLE;
        end else if (loop_q != LOOP_LAST) begin
          idx_d   = 2'd0;
          loop_d  = loop_q + 4'd1;
          a_d     = 1'b0;
          b_d     = 1'b0;
          state_d = SETTLE;
        end else begin
          // Verdict includes this final check, so it is ready in the DONE cycle.
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = (err_d == ERR_ZERO);
          state_d = DONE;
        end
      end

      DONE: begin
        a_d     = 1'b0;
        b_d     = 1'b0;
        state_d = IDLE;
      end

      default: begin
        a_d     = 1'b0;
        b_d     = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SETTLE) || (state_d == CHECK);
    done_d = (state_d == DONE);
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_gates_bist_checker.sv
// Scoreboard bench: stimulus queues expected run results, monitors check each cycle and on done.
module tb_gates_bist_checker;

  localparam int S    = 2;
  localparam int LAT1 = 4 * 1 * (S + 1) + 1;
  localparam int LAT2 = 4 * 2 * (S + 1) + 1;

  typedef struct {
    int         s;
    int         err;
    logic [6:0] mask;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start2;
  logic       a, b, busy, done, pass;
  logic [6:0] y_in, fail_mask;
  logic [3:0] err_count;
  logic       a2, b2, busy2, done2, pass2;
  logic [6:0] y2, mask2;
  logic [1:0] err2;

  int   mode   = 0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t q1[$];
  exp_t q2[$];

  gates_bist_checker #(.SETTLE_CYCLES(S), .LOOPS(1), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_mask(fail_mask)
  );

  gates_bist_checker #(.SETTLE_CYCLES(S), .LOOPS(2), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .y_in(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_mask(mask2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Bit order [6:0] = xnor, xor, nor, nand, not(a), or, and.
  function automatic logic [6:0] golden(input logic ga, input logic gb);
    return {~(ga ^ gb), ga ^ gb, ~(ga | gb), ~(ga & gb), ~ga, ga | gb, ga & gb};
  endfunction

  // Emulated gate unit with selectable faults.
  always_comb begin
    y_in = golden(a, b);
    case (mode)
      1: y_in[5] = ~y_in[5];
      2: y_in[0] = 1'b0;
      3: y_in = ~golden(a, b);
      4: y_in[2] = 1'b1;
      default: ;
    endcase
  end

  assign y2 = ~golden(a2, b2);

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor for the default instance: per-cycle stimulus sequence and end-of-run results.
  always @(negedge clk) begin : mon1
    int   ci;
    exp_t e;
    if (q1.size() > 0) begin
      ci = cyc - q1[0].s;
      if (ci == 1) begin
        chk("clr_err", err_count, 0);
        chk("clr_mask", fail_mask, 0);
        chk("clr_pass", pass, 0);
      end
      if (ci >= 1 && ci <= LAT1 - 1) begin
        chk("busy", busy, 1);
        chk("ab_seq", {a, b}, ((ci - 1) / (S + 1)) % 4);
        chk("done_early", done, 0);
      end
    end
    if (done) begin
      if (q1.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        e = q1.pop_front();
        chk("latency", cyc - e.s, LAT1);
        chk("err_count", err_count, e.err);
        chk("fail_mask", fail_mask, e.mask);
        chk("pass", pass, e.pass);
        chk("done_ab", {a, b}, 0);
        chk("done_busy", busy, 0);
      end
    end
  end

  // Monitor for the saturation instance.
  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2) begin
      if (q2.size() == 0) begin
        chk("unexpected_done2", done2, 0);
      end else begin
        e = q2.pop_front();
        chk("latency2", cyc - e.s, LAT2);
        chk("err_count2", err2, e.err);
        chk("fail_mask2", mask2, e.mask);
        chk("pass2", pass2, e.pass);
      end
    end
  end

  task automatic wait_q1();
    for (int i = 0; i < 200; i++) begin
      if (q1.size() == 0) break;
      @(negedge clk);
    end
    chk("timeout", q1.size(), 0);
    q1.delete();
  endtask

  // One run on the default instance; extra > 0 pulses start again at that cycle of the run.
  task automatic run1(input int m, input int e_err, input logic [6:0] e_mask,
                      input logic e_pass, input int extra);
    exp_t e;
    mode   = m;
    e.s    = cyc;
    e.err  = e_err;
    e.mask = e_mask;
    e.pass = e_pass;
    q1.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (extra > 0) begin
      repeat (extra - 2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_q1();
    repeat (3) @(negedge clk);
    chk("hold_err", err_count, e_err);
    chk("hold_mask", fail_mask, e_mask);
    chk("hold_pass", pass, e_pass);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    exp_t e;
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ab", {a, b}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_mask", fail_mask, 0);
    chk("rst_err2", err2, 0);
    rst = 1'b0;
    @(negedge clk);

    run1(0, 0, 7'h00, 1'b1, 0);
    run1(1, 4, 7'h20, 1'b0, 0);
    run1(0, 0, 7'h00, 1'b1, 5);
    run1(2, 1, 7'h01, 1'b0, 0);
    run1(4, 2, 7'h04, 1'b0, 0);

    // start held high: a second run begins from the IDLE cycle after DONE.
    mode   = 3;
    e.err  = 4;
    e.mask = 7'h7F;
    e.pass = 1'b0;
    e.s    = cyc;
    q1.push_back(e);
    e.s    = cyc + 14;
    q1.push_back(e);
    start  = 1'b1;
    wait_q1();
    start  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during the third vector's settle window.
    mode  = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_ab", {a, b}, 2);
    chk("pre_rst_err", err_count, 2);
    chk("pre_rst_mask", fail_mask, 7'h7F);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ab", {a, b}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err_count, 0);
    chk("abort_mask", fail_mask, 0);
    chk("abort_done", done, 0);
    repeat (15) @(negedge clk);
    run1(0, 0, 7'h00, 1'b1, 0);

    // Saturating counter, two loops, every output inverted.
    e.s    = cyc;
    e.err  = 3;
    e.mask = 7'h7F;
    e.pass = 1'b0;
    q2.push_back(e);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q2.size() == 0) break;
      @(negedge clk);
    end
    chk("timeout2", q2.size(), 0);
    q2.delete();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gates_bist_checker.md
Name: gates_bist_checker

Overview:
Hardware self-test engine for the two-input logic gate unit.
- Drives the gate unit's `a`/`b` inputs through all four input combinations.
- Waits a programmable settle time, then samples the seven gate outputs and compares them against an internal reference model.
- Accumulates a mismatch count and a sticky per-gate fail mask, and reports pass/fail.
- Sits beside the gate unit in the top level, opposite the stimulus side, so the unit can be checked on silicon/FPGA without a simulator.

Parameters:
- SETTLE_CYCLES, 2, cycles between driving a vector and sampling the outputs; legal range 1..255.
- LOOPS, 1, number of full passes over the 4-vector truth table; legal range 1..15.
- ERR_W, 4, width of the saturating error counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a test run; sampled only in IDLE.
- a  output  1  stimulus to the gate unit's `a` input, registered.
- b  output  1  stimulus to the gate unit's `b` input, registered.
- y_in  input  7  gate unit outputs: [0]and [1]or [2]not(a) [3]nand [4]nor [5]xor [6]xnor.
- busy  output  1  high while a run is in progress.
- done  output  1  single-cycle pulse at the end of a run.
- pass  output  1  1 when the last completed run had zero mismatches.
- err_count  output  ERR_W  number of mismatching vector checks, saturating.
- fail_mask  output  7  sticky OR of mismatching output bits across the run.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) sets:
  - state = IDLE
  - a = b = 0
  - busy = done = pass = 0
  - err_count = 0, fail_mask = 0
  - vector index = 0, loop count = 0, settle count = 0
- Reset mid-run aborts the run immediately: no done pulse, and all results are cleared.
- States:
  - IDLE: a = b = 0, busy = 0. If start=1, then on the next edge:
    - clear err_count, fail_mask and pass;
    - set idx = 0, loop = 0;
    - drive a = idx[1], b = idx[0];
    - go to SETTLE.
  - SETTLE: busy = 1. Lasts exactly SETTLE_CYCLES cycles, then goes to CHECK. a/b are held stable.
  - CHECK: busy = 1. Lasts one cycle.
    - Compute exp = reference outputs of (a, b); compute mism = y_in XOR exp.
    - fail_mask |= mism.
    - If mism != 0, increment err_count, saturating at 2^ERR_W - 1; it never wraps.
    - If idx < 3: idx++, update a/b on the same edge, go to SETTLE.
    - If idx == 3 and loop < LOOPS-1: idx = 0, loop++, go to SETTLE.
    - Otherwise go to DONE.
  - DONE: busy = 0, done = 1 for exactly this cycle.
    - pass = (err_count == 0) is registered on entry to DONE.
    - a = b = 0.
    - Next state is IDLE unconditionally.
- Handshake rules:
  - start while busy or in DONE is ignored; it is not queued.
  - start held high continuously re-triggers a run from every IDLE cycle.
- Latency: done is asserted 4·LOOPS·(SETTLE_CYCLES+1)+1 cycles after the edge that sampled start. With defaults this is cycle 13.
- Result hold: pass, err_count and fail_mask hold after the run until the next accepted start or reset.
- Error accounting: err_count counts vector checks with any mismatch, not mismatching bits. One bad vector with 3 wrong outputs adds 1.
- y_in is sampled only in CHECK; its value in all other states is don't-care.

Decomposition:
- Shared package gates_pkg holds:
  - GATE_W = 7;
  - output bit-index constants IDX_AND..IDX_XNOR;
  - state typedef {IDLE, SETTLE, CHECK, DONE}.
- Sub-module gates_ref_model: purely combinational (a, b) -> 7-bit expected vector, reusable by other checkers.
- The checker itself contains the FSM, counters and accumulators.

Test Plan:
- Correct gate unit connected, defaults, start pulse: a/b sequence 00,01,10,11, each held 3 cycles; done at cycle 13; pass=1, err_count=0, fail_mask=7'h00.
- y_in[5] forced to inverted xor: err_count=4, fail_mask=7'h20, pass=0.
- y_in[0] stuck at 0: mismatch only at vector 11; err_count=1, fail_mask=7'h01, pass=0.
- ERR_W=2, LOOPS=2, y_in = ~expected at all times: err_count saturates at 3 (not 0 after 8 errors), fail_mask=7'h7F, done at cycle 25.
- start pulsed again at cycle 5 of a run: ignored, done at cycle 13 only; a second start after done begins a new run and clears results.
- rst=1 during vector 2 SETTLE: next cycle a=b=0, busy=0, err_count=0; no done pulse; a subsequent start runs normally.
